// File: rtl/grid_access_sched.sv
// grid_access_sched
// Time-slot arbiter for the single-port 60x80 x 2-bit game-grid RAM (trail/border map).
// Even cycles (slot 0) belong to the VGA render read path. Odd cycles (slot 1) belong
// to the game engine. The engine clears the grid after reset/restart. It then runs one
// step per tick: write both trails, read both next cells and evaluate collisions.
//
// Ports
//   CLOCK_50, reset            system clock, synchronous active-high reset
//   reiniciar                  restart: abort any step, re-clear grid, clear game-over
//   tick                       one-cycle step request, accepted only while ready
//   p1/p2_cur_row/col          current cells, receive trail value 1 / 2
//   p1/p2_nxt_row/col          next cells, probed for collisions
//   pix_row/col                render cell request
//   pix_data, pix_valid        registered render result, valid pulse
//   mem_addr/we/wdata          external RAM port (combinational mux)
//   mem_rdata                  RAM read data, valid one cycle after the address
//   ready, step_done           engine idle / end-of-step pulse
//   collide1/2, game_over      last step result and sticky game-over flag
module grid_access_sched #(
  parameter int ROWS   = 60,
  parameter int COLS   = 80,
  parameter int BORDER = 2,
  parameter int AW     = 13
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          reiniciar,
  input  logic          tick,
  input  logic [5:0]    p1_cur_row,
  input  logic [6:0]    p1_cur_col,
  input  logic [5:0]    p1_nxt_row,
  input  logic [6:0]    p1_nxt_col,
  input  logic [5:0]    p2_cur_row,
  input  logic [6:0]    p2_cur_col,
  input  logic [5:0]    p2_nxt_row,
  input  logic [6:0]    p2_nxt_col,
  input  logic [5:0]    pix_row,
  input  logic [6:0]    pix_col,
  output logic [1:0]    pix_data,
  output logic          pix_valid,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_wdata,
  input  logic [1:0]    mem_rdata,
  output logic          ready,
  output logic          step_done,
  output logic          collide1,
  output logic          collide2,
  output logic          game_over
);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_WR1, S_WR2, S_RD1, S_RD2, S_EVAL, S_OVER
  } state_t;

  localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);
  localparam logic [6:0] COL_LAST = 7'(COLS - 1);
  localparam logic [5:0] ROW_B_LO = 6'(BORDER);
  localparam logic [5:0] ROW_B_HI = 6'(ROWS - BORDER);
  localparam logic [6:0] COL_B_LO = 7'(BORDER);
  localparam logic [6:0] COL_B_HI = 7'(COLS - BORDER);

  function automatic logic in_grid(input logic [5:0] r, input logic [6:0] c);
    return (r <= ROW_LAST) && (c <= COL_LAST);
  endfunction

  // row*80 + col built from shifts; the largest legal cell is 4799, so AW bits never wrap
  function automatic logic [AW-1:0] cell_addr(input logic [5:0] r, input logic [6:0] c);
    return (AW'(r) << 6) + (AW'(r) << 4) + AW'(c);
  endfunction

  state_t     state, state_nxt;
  logic       slot;
  logic [5:0] clr_row;
  logic [6:0] clr_col;
  logic       tick_pend;
  logic [5:0] p1c_r, p1n_r, p2c_r, p2n_r;
  logic [6:0] p1c_c, p1n_c, p2c_c, p2n_c;
  logic [1:0] rd1;
  logic       render_d1, pix_ok_d1;
  logic       clr_border, clr_last, pix_ok;
  logic       p1c_ok, p2c_ok, p1n_ok, p2n_ok, same_nxt, hit1, hit2;

  assign clr_border = (clr_row < ROW_B_LO) || (clr_row >= ROW_B_HI) ||
                      (clr_col < COL_B_LO) || (clr_col >= COL_B_HI);
  assign clr_last   = (clr_row == ROW_LAST) && (clr_col == COL_LAST);
  assign pix_ok     = in_grid(pix_row, pix_col);
  assign p1c_ok     = in_grid(p1c_r, p1c_c);
  assign p2c_ok     = in_grid(p2c_r, p2c_c);
  assign p1n_ok     = in_grid(p1n_r, p1n_c);
  assign p2n_ok     = in_grid(p2n_r, p2n_c);
  assign same_nxt   = (p1n_r == p2n_r) && (p1n_c == p2n_c);

  // Collisions are resolved in the render-slot half of EVAL. rd1 was captured one slot
  // earlier. The p2 probe is still on mem_rdata at that point, so it needs no register.
  assign hit1 = (rd1 != 2'd0) || !p1n_ok || same_nxt;
  assign hit2 = (mem_rdata != 2'd0) || !p2n_ok || same_nxt;

  assign ready     = (state == S_IDLE);
  assign step_done = slot && (state == S_EVAL);

  // Slot phase: only a full reset realigns it, restart leaves it running
  always_ff @(posedge CLOCK_50) begin
    if (reset) slot <= 1'b0;
    else       slot <= ~slot;
  end

  // Engine state, clear counters, render pipeline and step results
  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciar) begin
      state     <= S_CLEAR;
      clr_row   <= '0;
      clr_col   <= '0;
      tick_pend <= 1'b0;
      rd1       <= '0;
      render_d1 <= 1'b0;
      pix_ok_d1 <= 1'b0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      collide1  <= 1'b0;
      collide2  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      // A tick landing on a render cycle while idle is held for the next engine slot
      tick_pend <= (state == S_IDLE) && !slot && tick;
      render_d1 <= !slot;
      pix_ok_d1 <= pix_ok;
      pix_valid <= render_d1;
      if (render_d1) pix_data <= pix_ok_d1 ? mem_rdata : 2'd0;
      if (slot && (state == S_CLEAR)) begin
        if (clr_col == COL_LAST) begin
          clr_col <= '0;
          clr_row <= clr_row + 6'd1;
        end else begin
          clr_col <= clr_col + 7'd1;
        end
      end
      if (!slot && (state == S_RD2)) rd1 <= mem_rdata;
      if (!slot && (state == S_EVAL)) begin
        collide1  <= hit1;
        collide2  <= hit2;
        game_over <= game_over | hit1 | hit2;
      end
    end
  end

  // Step coordinates are frozen when the tick is seen so a step sees one consistent move
  always_ff @(posedge CLOCK_50) begin
    if ((state == S_IDLE) && tick) begin
      p1c_r <= p1_cur_row;
      p1c_c <= p1_cur_col;
      p1n_r <= p1_nxt_row;
      p1n_c <= p1_nxt_col;
      p2c_r <= p2_cur_row;
      p2c_c <= p2_cur_col;
      p2n_r <= p2_nxt_row;
      p2n_c <= p2_nxt_col;
    end
  end

  // RAM port mux and next state; the FSM only moves on engine slots
  always_comb begin
    state_nxt = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 2'd0;
    if (!slot) begin
      mem_addr = pix_ok ? cell_addr(pix_row, pix_col) : '0;
    end else begin
      case (state)
        S_CLEAR: begin
          mem_addr  = cell_addr(clr_row, clr_col);
          mem_we    = 1'b1;
          mem_wdata = clr_border ? 2'd3 : 2'd0;
          if (clr_last) state_nxt = S_IDLE;
        end
        S_IDLE: if (tick || tick_pend) state_nxt = S_WR1;
        S_WR1: begin
          mem_addr  = p1c_ok ? cell_addr(p1c_r, p1c_c) : '0;
          mem_we    = p1c_ok;
          mem_wdata = 2'd1;
          state_nxt = S_WR2;
        end
        S_WR2: begin
          mem_addr  = p2c_ok ? cell_addr(p2c_r, p2c_c) : '0;
          mem_we    = p2c_ok;
          mem_wdata = 2'd2;
          state_nxt = S_RD1;
        end
        S_RD1: begin
          mem_addr  = p1n_ok ? cell_addr(p1n_r, p1n_c) : '0;
          state_nxt = S_RD2;
        end
        S_RD2: begin
          mem_addr  = p2n_ok ? cell_addr(p2n_r, p2n_c) : '0;
          state_nxt = S_EVAL;
        end
        S_EVAL:  state_nxt = (collide1 || collide2) ? S_OVER : S_IDLE;
        S_OVER:  state_nxt = S_OVER;
        default: state_nxt = S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_access_sched.sv
// tb_grid_access_sched
// Directed bench for grid_access_sched with a sync-read RAM model. Stimulus is driven
// and outputs are sampled on the falling clock edge.
module tb_grid_access_sched;

  logic        CLOCK_50 = 1'b0;
  logic        reset, reiniciar, tick;
  logic [5:0]  p1_cur_row, p1_nxt_row, p2_cur_row, p2_nxt_row, pix_row;
  logic [6:0]  p1_cur_col, p1_nxt_col, p2_cur_col, p2_nxt_col, pix_col;
  logic [1:0]  pix_data, mem_wdata, mem_rdata;
  logic        pix_valid, mem_we, ready, step_done, collide1, collide2, game_over;
  logic [12:0] mem_addr;

  logic [1:0]  ram [0:4799];
  int          cyc;
  int          checks_total = 0;
  int          checks_passed = 0;
  int          slot0_we = 0;
  int          we_total = 0;
  int          step_we = 0;
  int          step_pulses = 0;

  grid_access_sched dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .reiniciar(reiniciar), .tick(tick),
    .p1_cur_row(p1_cur_row), .p1_cur_col(p1_cur_col),
    .p1_nxt_row(p1_nxt_row), .p1_nxt_col(p1_nxt_col),
    .p2_cur_row(p2_cur_row), .p2_cur_col(p2_cur_col),
    .p2_nxt_row(p2_nxt_row), .p2_nxt_col(p2_nxt_col),
    .pix_row(pix_row), .pix_col(pix_col), .pix_data(pix_data), .pix_valid(pix_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .ready(ready), .step_done(step_done), .collide1(collide1), .collide2(collide2),
    .game_over(game_over)
  );

  // 50 MHz clock
  always #10 CLOCK_50 = ~CLOCK_50;

  // Cycle counter aligned with the slot: cycle 0 is the first cycle after reset (slot 0)
  always @(posedge CLOCK_50) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Sync-read RAM model, pre-filled with a nonzero pattern so cleared cells are visible
  always @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < 4800; i++) ram[i] <= 2'd2;
      mem_rdata <= 2'd0;
    end else begin
      if (mem_we && (mem_addr < 13'd4800)) ram[mem_addr] <= mem_wdata;
      mem_rdata <= (mem_addr < 13'd4800) ? ram[mem_addr] : 2'd0;
    end
  end

  // Bus activity counters used by several tests
  always @(negedge CLOCK_50) begin
    if (mem_we && (cyc[0] == 1'b0)) slot0_we <= slot0_we + 1;
    if (mem_we) we_total <= we_total + 1;
    if (mem_we && ((mem_wdata == 2'd1) || (mem_wdata == 2'd2))) step_we <= step_we + 1;
    if (step_done) step_pulses <= step_pulses + 1;
  end

  function automatic int addrOf(input int r, input int c);
    return r * 80 + c;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks_total++;
    if (observed == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Issue one tick on an engine-slot cycle; returns the cycle the tick was high
  task automatic applyStimulus(input int a_r, input int a_c, input int an_r, input int an_c,
                               input int b_r, input int b_c, input int bn_r, input int bn_c,
                               output int tick_cyc);
    @(negedge CLOCK_50);
    if (cyc[0] == 1'b0) @(negedge CLOCK_50);
    p1_cur_row = 6'(a_r);  p1_cur_col = 7'(a_c);
    p1_nxt_row = 6'(an_r); p1_nxt_col = 7'(an_c);
    p2_cur_row = 6'(b_r);  p2_cur_col = 7'(b_c);
    p2_nxt_row = 6'(bn_r); p2_nxt_col = 7'(bn_c);
    tick = 1'b1;
    tick_cyc = cyc;
    @(negedge CLOCK_50);
    tick = 1'b0;
  endtask

  task automatic waitReady(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (ready) begin
        at = cyc;
        break;
      end
      @(negedge CLOCK_50);
    end
  endtask

  task automatic waitStepDone(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      if (step_done) begin
        at = cyc;
        break;
      end
      @(negedge CLOCK_50);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run did not finish, got %0d checks, expected completion", checks_total);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, r, at, snap_we, snap_pulse, snap_step, first_addr;
    reset = 1'b1; reiniciar = 1'b0; tick = 1'b0;
    p1_cur_row = '0; p1_cur_col = '0; p1_nxt_row = '0; p1_nxt_col = '0;
    p2_cur_row = '0; p2_cur_col = '0; p2_nxt_row = '0; p2_nxt_col = '0;
    pix_row = '0; pix_col = '0;
    repeat (3) @(negedge CLOCK_50);

    $display("[TB] reset values");
    checkOutput("rst_ready", int'(ready), 0);
    checkOutput("rst_pix_valid", int'(pix_valid), 0);
    checkOutput("rst_pix_data", int'(pix_data), 0);
    checkOutput("rst_step_done", int'(step_done), 0);
    checkOutput("rst_collide1", int'(collide1), 0);
    checkOutput("rst_collide2", int'(collide2), 0);
    checkOutput("rst_game_over", int'(game_over), 0);
    checkOutput("rst_mem_we", int'(mem_we), 0);
    reset = 1'b0;

    $display("[TB] grid clear after reset");
    repeat (100) @(negedge CLOCK_50);
    checkOutput("clear_busy_ready", int'(ready), 0);
    waitReady(9700, at);
    checkOutput("clear_ready_cycle", at, 9600);
    checkOutput("cell_0_0", int'(ram[addrOf(0, 0)]), 3);
    checkOutput("cell_1_40", int'(ram[addrOf(1, 40)]), 3);
    checkOutput("cell_2_2", int'(ram[addrOf(2, 2)]), 0);
    checkOutput("cell_57_77", int'(ram[addrOf(57, 77)]), 0);
    checkOutput("cell_58_40", int'(ram[addrOf(58, 40)]), 3);
    checkOutput("cell_30_79", int'(ram[addrOf(30, 79)]), 3);

    $display("[TB] normal step");
    applyStimulus(30, 27, 30, 28, 30, 52, 30, 51, t);
    waitStepDone(at);
    checkOutput("t2_step_latency", at - t, 10);
    checkOutput("t2_collide1", int'(collide1), 0);
    checkOutput("t2_collide2", int'(collide2), 0);
    checkOutput("t2_trail1", int'(ram[addrOf(30, 27)]), 1);
    checkOutput("t2_trail2", int'(ram[addrOf(30, 52)]), 2);
    @(negedge CLOCK_50);
    checkOutput("t2_step_done_pulse", int'(step_done), 0);
    checkOutput("t2_ready_again", int'(ready), 1);

    $display("[TB] render path");
    if (cyc[0] == 1'b0) @(negedge CLOCK_50);
    pix_row = 6'd30; pix_col = 7'd27;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("pix_valid_gap", int'(pix_valid), 0);
    @(negedge CLOCK_50);
    checkOutput("pix_valid_trail1", int'(pix_valid), 1);
    checkOutput("pix_data_trail1", int'(pix_data), 1);
    pix_row = 6'd61; pix_col = 7'd0;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("pix_data_row_oor", int'(pix_data), 0);
    checkOutput("pix_valid_row_oor", int'(pix_valid), 1);
    pix_row = 6'd30; pix_col = 7'd52;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("pix_data_trail2", int'(pix_data), 2);
    pix_row = 6'd5; pix_col = 7'd100;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("pix_data_col_oor", int'(pix_data), 0);

    $display("[TB] wall collision");
    applyStimulus(30, 28, 1, 10, 30, 51, 30, 50, t);
    waitStepDone(at);
    checkOutput("t3_step_latency", at - t, 10);
    checkOutput("t3_collide1", int'(collide1), 1);
    checkOutput("t3_collide2", int'(collide2), 0);
    checkOutput("t3_game_over", int'(game_over), 1);
    @(negedge CLOCK_50);
    checkOutput("t3_ready_over", int'(ready), 0);
    snap_we = we_total;
    snap_pulse = step_pulses;
    applyStimulus(30, 29, 30, 30, 30, 50, 30, 49, t);
    repeat (30) @(negedge CLOCK_50);
    checkOutput("t3_no_write_in_over", we_total - snap_we, 0);
    checkOutput("t3_no_step_in_over", step_pulses - snap_pulse, 0);
    checkOutput("t3_game_over_sticky", int'(game_over), 1);

    $display("[TB] restart from game over");
    if (cyc[0] == 1'b1) @(negedge CLOCK_50);
    reiniciar = 1'b1;
    r = cyc;
    @(negedge CLOCK_50);
    reiniciar = 1'b0;
    checkOutput("rst2_game_over", int'(game_over), 0);
    checkOutput("rst2_collide1", int'(collide1), 0);
    waitReady(9700, at);
    checkOutput("rst2_ready_cycle", at - r, 9600);

    $display("[TB] restart during RD1");
    applyStimulus(20, 20, 20, 21, 25, 25, 25, 26, t);
    repeat (4) @(negedge CLOCK_50);
    checkOutput("t6_trail1_before", int'(ram[addrOf(20, 20)]), 1);
    checkOutput("t6_trail2_before", int'(ram[addrOf(25, 25)]), 2);
    reiniciar = 1'b1;
    r = cyc;
    snap_step = step_we;
    snap_pulse = step_pulses;
    @(negedge CLOCK_50);
    reiniciar = 1'b0;
    checkOutput("t6_game_over", int'(game_over), 0);
    first_addr = -1;
    for (int i = 0; i < 8; i++) begin
      if (mem_we) begin
        first_addr = int'(mem_addr);
        break;
      end
      @(negedge CLOCK_50);
    end
    checkOutput("t6_clear_restart_addr", first_addr, 0);
    waitReady(9700, at);
    checkOutput("t6_ready_cycle", at - r, 9600);
    checkOutput("t6_no_step_writes", step_we - snap_step, 0);
    checkOutput("t6_no_step_done", step_pulses - snap_pulse, 0);
    checkOutput("t6_trail1_cleared", int'(ram[addrOf(20, 20)]), 0);

    $display("[TB] head-on collision");
    applyStimulus(30, 38, 30, 40, 30, 42, 30, 40, t);
    waitStepDone(at);
    checkOutput("t4_step_latency", at - t, 10);
    checkOutput("t4_collide1", int'(collide1), 1);
    checkOutput("t4_collide2", int'(collide2), 1);
    checkOutput("t4_game_over", int'(game_over), 1);

    @(negedge CLOCK_50);
    checkOutput("slot0_no_write", slot0_we, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
